adpll_lock_detector: RTL and testbench

- Monitors the ring ADPLL's phase error and DCO control code in the `fpga_clk_i` domain, and raises a lock flag once the error has stayed small for enough reference periods.
- Counts loss-of-lock events and records the DCO code excursion seen while locked.
- Sits directly downstream of the ADPLL top level and consumes its `error_o` and `dco_cc_o` outputs.
- Its outputs drive status LEDs and debug readout.

---
 rtl/adpll_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 22 ++
 rtl/adpll_lock_detector.sv | 171 +++++++++++++++++
 tb/tb_adpll_lock_detector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: lock-detector state encoding and default datapath widths.
package adpll_pkg;

  localparam int ADPLL_ERROR_WIDTH  = 8;
  localparam int ADPLL_DCO_CC_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLD     = 2'd3
  } lock_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// 2-flop synchronizer followed by one delay flop; rise_o pulses one cycle per synchronized rising edge.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync_o,
  output logic dly_o,
  output logic rise_o
);

  logic [2:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= '0;
    else         ff_q <= {ff_q[1:0], d_i};
  end

  assign sync_o = ff_q[1];
  assign dly_o  = ff_q[2];
  assign rise_o = ff_q[1] & ~ff_q[2];

endmodule

// File: rtl/adpll_lock_detector.sv
// ADPLL lock detector: ref-strobed error window FSM, slip counter and locked DCO-code excursion.
module adpll_lock_detector
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH  = ADPLL_ERROR_WIDTH,
  parameter int DCO_CC_WIDTH = ADPLL_DCO_CC_WIDTH,
  parameter int LOCK_THRESH  = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int SLIP_WIDTH   = 8
) (
  input  logic                           fpga_clk_i,
  input  logic                           reset_n_i,
  input  logic                           enable_i,
  input  logic                           ref_clk_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
  output logic                           lock_o,
  output logic [1:0]                     state_o,
  output logic [SLIP_WIDTH-1:0]          slip_count_o,
  output logic signed [DCO_CC_WIDTH-1:0] dco_min_o,
  output logic signed [DCO_CC_WIDTH-1:0] dco_max_o
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GW-1:0]          LOCK_N   = GW'(LOCK_COUNT);
  localparam logic [BW-1:0]          UNLOCK_N = BW'(UNLOCK_COUNT);
  localparam logic [ERROR_WIDTH:0]   THRESH   = (ERROR_WIDTH+1)'(LOCK_THRESH);

  // ref strobe
  logic ref_sync_unused, ref_dly_unused, sample;

  sync_edge_detect u_ref_sync (
    .clk_i  (fpga_clk_i),
    .rst_ni (reset_n_i),
    .d_i    (ref_clk_i),
    .sync_o (ref_sync_unused),
    .dly_o  (ref_dly_unused),
    .rise_o (sample)
  );

  // Per-bit DCO chain; a code is accepted only once two consecutive synchronized values agree.
  logic [DCO_CC_WIDTH-1:0] dco_sync, dco_dly, dco_rise_unused;
  logic signed [DCO_CC_WIDTH-1:0] dco_acc_q;

  for (genvar b = 0; b < DCO_CC_WIDTH; b++) begin : g_dco_sync
    sync_edge_detect u_dco_sync (
      .clk_i  (fpga_clk_i),
      .rst_ni (reset_n_i),
      .d_i    (dco_cc_i[b]),
      .sync_o (dco_sync[b]),
      .dly_o  (dco_dly[b]),
      .rise_o (dco_rise_unused[b])
    );
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i)              dco_acc_q <= '0;
    else if (dco_sync == dco_dly) dco_acc_q <= $signed(dco_dly);
  end

  // Extra magnitude bit so the most negative error maps to a correct positive value.
  logic signed [ERROR_WIDTH:0] err_ext;
  logic        [ERROR_WIDTH:0] err_abs;
  logic                        in_win;

  assign err_ext = {error_i[ERROR_WIDTH-1], error_i};
  assign err_abs = err_ext[ERROR_WIDTH] ? $unsigned(-err_ext) : $unsigned(err_ext);
  assign in_win  = (err_abs <= THRESH);

  lock_state_e                    state_q, state_d;
  logic [GW-1:0]                  good_q, good_d, good_inc;
  logic [BW-1:0]                  bad_q, bad_d, bad_inc;
  logic [SLIP_WIDTH-1:0]          slip_q, slip_d;
  logic signed [DCO_CC_WIDTH-1:0] min_q, min_d, max_q, max_d;

  assign good_inc = good_q + GW'(1);
  assign bad_inc  = bad_q + BW'(1);

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_UNLOCKED;
      good_q  <= '0;
      bad_q   <= '0;
      slip_q  <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      slip_q  <= slip_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    slip_d  = slip_q;
    min_d   = min_q;
    max_d   = max_q;
    if (!enable_i) begin
      state_d = ST_UNLOCKED;
      good_d  = '0;
      bad_d   = '0;
    end else if (sample) begin
      if (state_q == ST_LOCKED || state_q == ST_HOLD) begin
        if (dco_acc_q < min_q) min_d = dco_acc_q;
        if (dco_acc_q > max_q) max_d = dco_acc_q;
      end
      case (state_q)
        ST_UNLOCKED: begin
          if (in_win && LOCK_COUNT == 1) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            min_d   = dco_acc_q;
            max_d   = dco_acc_q;
          end else if (in_win) begin
            state_d = ST_ACQUIRE;
            good_d  = GW'(1);
          end else begin
            good_d  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (!in_win) begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
          end else if (good_inc == LOCK_N) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            min_d   = dco_acc_q;
            max_d   = dco_acc_q;
          end else begin
            good_d  = good_inc;
          end
        end
        ST_LOCKED: begin
          if (!in_win) begin
            state_d = ST_HOLD;
            bad_d   = BW'(1);
          end
        end
        ST_HOLD: begin
          if (in_win) begin
            state_d = ST_LOCKED;
            bad_d   = '0;
          end else if (bad_inc == UNLOCK_N) begin
            state_d = ST_UNLOCKED;
            bad_d   = '0;
            if (slip_q != '1) slip_d = slip_q + SLIP_WIDTH'(1);
          end else begin
            bad_d   = bad_inc;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  assign lock_o       = (state_q == ST_LOCKED) || (state_q == ST_HOLD);
  assign state_o      = state_q;
  assign slip_count_o = slip_q;
  assign dco_min_o    = min_q;
  assign dco_max_o    = max_q;

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Directed bench for adpll_lock_detector: lock/hold/slip sequencing, error window edges, DCO excursion.
module tb_adpll_lock_detector;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b1;
  logic              ref_clk = 1'b0;
  logic signed [7:0] err = '0;
  logic signed [4:0] dco = '0;
  logic              lock;
  logic [1:0]        state;
  logic [7:0]        slip;
  logic signed [4:0] dmin, dmax;

  int n_tests = 0;
  int n_fail  = 0;

  adpll_lock_detector dut (
    .fpga_clk_i   (clk),
    .reset_n_i    (rst_n),
    .enable_i     (enable),
    .ref_clk_i    (ref_clk),
    .error_i      (err),
    .dco_cc_i     (dco),
    .lock_o       (lock),
    .state_o      (state),
    .slip_count_o (slip),
    .dco_min_o    (dmin),
    .dco_max_o    (dmax)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One ref period per iteration: high 3 cycles, low 3+ cycles; sample lands 3 edges after the rise.
  task automatic pulse(input int n);
    repeat (n) begin
      @(posedge clk); #1 ref_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1 ref_clk = 1'b0;
      repeat (3) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic set_dco(input logic signed [4:0] v);
    dco = v;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lock",  lock, 0);
    chk("rst_state", state, 0);
    chk("rst_slip",  slip, 0);
    chk("rst_min",   dmin, 0);
    chk("rst_max",   dmax, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 15 in-window then threshold+1 aborts acquisition
    err = 8'sd1;
    pulse(15);
    chk("acq15_state", state, 1);
    chk("acq15_lock",  lock, 0);
    err = 8'sd3;
    pulse(1);
    chk("abort_state", state, 0);

    // Full acquisition; watch lock_o timing on the 16th edge
    set_dco(-5'sd3);
    err = 8'sd1;
    pulse(15);
    chk("pre16_state", state, 1);
    @(posedge clk); #1 ref_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("lock_at_sample", lock, 0);
    @(negedge clk);
    chk("lock_after_sample", lock, 1);
    ref_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("locked_state", state, 2);
    chk("lock_min", dmin, -3);
    chk("lock_max", dmax, -3);

    // DCO excursion with errors at the window edge (+2 / -2)
    set_dco(5'sd5);  err = 8'sd2;  pulse(1);
    set_dco(-5'sd7); err = -8'sd2; pulse(1);
    set_dco(5'sd2);  err = 8'sd2;  pulse(1);
    chk("exc_state", state, 2);
    chk("exc_min", dmin, -7);
    chk("exc_max", dmax, 5);

    // Most negative error: 3 bad samples -> HOLD, recover
    err = 8'sh80;
    pulse(3);
    chk("hold_state", state, 3);
    chk("hold_lock",  lock, 1);
    err = 8'sd0;
    pulse(1);
    chk("recover_state", state, 2);
    chk("recover_slip",  slip, 0);

    // 4 bad samples -> slip
    err = 8'sh80;
    pulse(4);
    chk("slip_state", state, 0);
    chk("slip_lock",  lock, 0);
    chk("slip_cnt",   slip, 1);
    chk("held_min",   dmin, -7);
    chk("held_max",   dmax, 5);

    // Relock reloads min/max; enable low is not a slip
    err = 8'sd0;
    pulse(16);
    chk("relock_state", state, 2);
    chk("relock_min", dmin, 2);
    chk("relock_max", dmax, 2);
    enable = 1'b0;
    @(negedge clk);
    chk("en_state", state, 0);
    chk("en_slip",  slip, 1);
    pulse(2);
    chk("en_hold_state", state, 0);
    enable = 1'b1;

    // Drive slip counter to saturation
    for (int i = 0; i < 254; i++) begin
      err = 8'sd0;   pulse(16);
      err = 8'sh80;  pulse(4);
    end
    chk("sat_slip", slip, 255);
    err = 8'sd0;   pulse(16);
    chk("sat_locked", state, 2);
    err = 8'sh80;  pulse(4);
    chk("sat_slip_hold", slip, 255);
    chk("sat_state", state, 0);

    // Asynchronous reset mid-acquire
    err = 8'sd0;
    pulse(10);
    chk("mid_acq_state", state, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_lock",  lock, 0);
    chk("arst_slip",  slip, 0);
    chk("arst_min",   dmin, 0);
    chk("arst_max",   dmax, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(15);
    chk("post_rst15_lock",  lock, 0);
    chk("post_rst15_state", state, 1);
    pulse(1);
    chk("post_rst16_lock", lock, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
